ula_issue_ctrl: RTL

- Multicycle issue and writeback stage that sits directly upstream of the 16-bit ALU.
- Accepts 16-bit instructions over a valid/ready handshake and holds an 8 x 16 register bank.
- Drives the ALU's A, Ry and 3-bit OpSelect inputs, captures the ALU result and writes it back.
- Also handles ldi (load immediate), out (output port pulse) and rep (hardware repeat of the last arithmetic instruction).

---
 rtl/ula_issue_ctrl_pkg.sv | 60 ++++++
 rtl/ula_reg_bank.sv | 46 ++++
 rtl/ula_issue_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ula_issue_ctrl_pkg.sv
// Shared definitions for the ULA issue/writeback stage: datapath sizes,
// opcode encodings, instruction field positions, FSM states and the
// last-arithmetic-op record replayed by rep.
package ula_issue_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int RIDX_W = 3;
  localparam int REP_W  = 10;
  localparam int OP_W   = 3;

  // Opcodes; 3'b011 and 3'b110 are undefined and reported as illegal
  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_NAND = 3'b010;
  localparam logic [OP_W-1:0] OP_OUT  = 3'b100;
  localparam logic [OP_W-1:0] OP_LDI  = 3'b101;
  localparam logic [OP_W-1:0] OP_REP  = 3'b111;

  // ALU select that passes A straight through (also the idle select)
  localparam logic [OP_W-1:0] ALU_PASS_A = OP_OUT;

  // Instruction field positions; imm overlaps ry
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int RX_HI  = 12;
  localparam int RX_LO  = 10;
  localparam int RY_HI  = 9;
  localparam int RY_LO  = 7;
  localparam int IMM_HI = REP_W - 1;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_WB,
    S_REP_EXEC,
    S_REP_WB
  } state_t;

  // Most recent add/sub/nand, replayed by rep; valid=0 means "none"
  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [RIDX_W-1:0] rx;
    logic [RIDX_W-1:0] ry;
  } last_op_t;

  // ALU OpSelect for an opcode: real ops pass through, everything else
  // parks the ALU on pass-A
  function automatic logic [OP_W-1:0] alu_sel(input logic [OP_W-1:0] op);
    logic [OP_W-1:0] sel;
    case (op)
      OP_ADD, OP_SUB, OP_NAND, OP_OUT: sel = op;
      default:                         sel = ALU_PASS_A;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ula_reg_bank.sv
// NREGS x DATA_W register bank: two asynchronous read ports, one
// synchronous write port, async clear on reset.
// Build option ULA_R0_ZERO_EN: R0 reads as zero and writes to it are dropped.
module ula_reg_bank
  import ula_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [RIDX_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [RIDX_W-1:0] i_raddr_a,
  input  logic [RIDX_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  output logic              o_wr_commit
);

  logic [DATA_W-1:0] r_regs [NREGS];

`ifdef ULA_R0_ZERO_EN
  // R0 is hardwired to zero: reads forced, writes suppressed
  assign o_wr_commit = i_we && (i_waddr != '0);
  assign o_rdata_a   = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
  assign o_rdata_b   = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];
`else
  assign o_wr_commit = i_we;
  assign o_rdata_a   = r_regs[i_raddr_a];
  assign o_rdata_b   = r_regs[i_raddr_b];
`endif

  // Register storage: cleared on reset, one write per cycle
  // NOTE: this bank is architecturally visible and must read 0 after
  // reset, so every entry is cleared; that keeps it in flops, not a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (o_wr_commit) begin
      // NOTE: non-blocking so every reader this cycle sees the old value.
      r_regs[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: rtl/ula_issue_ctrl.sv
// Multicycle issue/writeback stage in front of the 16-bit ALU.
// IDLE -> EXEC -> WB per instruction; rep replays the last arithmetic op
// through REP_EXEC/REP_WB pairs. Build option ULA_R0_ZERO_EN (handled in
// ula_reg_bank) makes R0 a constant zero.
module ula_issue_ctrl
  import ula_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_ry,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy_rep,
  output logic              illegal
);

  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_instr;
  last_op_t          r_last;
  logic [REP_W-1:0]  r_count;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_ry;
  logic [OP_W-1:0]   r_alu_op;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_illegal;

  // Fields of the latched instruction
  logic [OP_W-1:0]   w_op;
  logic [RIDX_W-1:0] w_rx;
  logic [RIDX_W-1:0] w_ry;
  logic [REP_W-1:0]  w_imm;

  assign w_op  = r_instr[OPC_HI:OPC_LO];
  assign w_rx  = r_instr[RX_HI:RX_LO];
  assign w_ry  = r_instr[RY_HI:RY_LO];
  assign w_imm = r_instr[IMM_HI:IMM_LO];

  // Control produced by the FSM
  logic              w_load_ops;
  logic [OP_W-1:0]   w_next_alu_op;
  logic [RIDX_W-1:0] w_raddr_a;
  logic [RIDX_W-1:0] w_raddr_b;
  logic              w_we;
  logic [RIDX_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_set_count;
  logic              w_dec_count;
  logic              w_upd_last;
  logic              w_cap_out;
  logic              w_flag_ill;

  // Register bank interface
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic              w_wr_commit;
  logic [DATA_W-1:0] w_opnd_a;
  logic [DATA_W-1:0] w_opnd_b;

  ula_reg_bank u_reg_bank (
    .clk         (clk),
    .rst         (rst),
    .i_we        (w_we),
    .i_waddr     (w_waddr),
    .i_wdata     (w_wdata),
    .i_raddr_a   (w_raddr_a),
    .i_raddr_b   (w_raddr_b),
    .o_rdata_a   (w_rd_a),
    .o_rdata_b   (w_rd_b),
    .o_wr_commit (w_wr_commit)
  );

  // Operands for the next EXEC are loaded on the same edge REP_WB writes
  // the bank, so a committed write is forwarded to keep replays chained.
  assign w_opnd_a = (w_wr_commit && (w_waddr == w_raddr_a)) ? w_wdata : w_rd_a;
  assign w_opnd_b = (w_wr_commit && (w_waddr == w_raddr_b)) ? w_wdata : w_rd_b;

  // Next-state and per-state control decode
  always_comb begin
    // NOTE: every output gets a default first, so no path infers a latch.
    w_next_state  = r_state;
    w_raddr_a     = r_last.rx;
    w_raddr_b     = r_last.ry;
    w_load_ops    = 1'b0;
    w_next_alu_op = ALU_PASS_A;
    w_we          = 1'b0;
    w_waddr       = r_last.rx;
    w_wdata       = alu_result;
    w_set_count   = 1'b0;
    w_dec_count   = 1'b0;
    w_upd_last    = 1'b0;
    w_cap_out     = 1'b0;
    w_flag_ill    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_raddr_a = instr[RX_HI:RX_LO];
        w_raddr_b = instr[RY_HI:RY_LO];
        if (instr_valid) begin
          w_next_state  = S_EXEC;
          w_load_ops    = 1'b1;
          w_next_alu_op = alu_sel(instr[OPC_HI:OPC_LO]);
        end
      end

      S_EXEC: w_next_state = S_WB;

      S_WB: begin
        w_next_state = S_IDLE;
        case (w_op)
          OP_ADD, OP_SUB, OP_NAND: begin
            w_we       = 1'b1;
            w_waddr    = w_rx;
            w_wdata    = alu_result;
            w_upd_last = 1'b1;
          end
          OP_OUT: w_cap_out = 1'b1;
          OP_LDI: begin
            w_we    = 1'b1;
            w_waddr = w_rx;
            w_wdata = {{(DATA_W - REP_W){1'b0}}, w_imm};
          end
          OP_REP: begin
            if ((w_imm != '0) && r_last.valid) begin
              w_next_state  = S_REP_EXEC;
              w_set_count   = 1'b1;
              w_load_ops    = 1'b1;
              w_next_alu_op = r_last.op;
            end
          end
          default: w_flag_ill = 1'b1;
        endcase
      end

      S_REP_EXEC: w_next_state = S_REP_WB;

      S_REP_WB: begin
        w_we        = 1'b1;
        w_waddr     = r_last.rx;
        w_wdata     = alu_result;
        w_dec_count = 1'b1;
        if (r_count == REP_W'(1)) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state  = S_REP_EXEC;
          w_load_ops    = 1'b1;
          w_next_alu_op = r_last.op;
        end
      end

      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Instruction latch, last arithmetic op and repeat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= '0;
      r_last  <= '0;
      r_count <= '0;
    end else begin
      if ((r_state == S_IDLE) && instr_valid) r_instr <= instr;
      if (w_upd_last) r_last <= '{valid: 1'b1, op: w_op, rx: w_rx, ry: w_ry};
      if (w_set_count)      r_count <= w_imm;
      else if (w_dec_count) r_count <= r_count - 1'b1;
    end
  end

  // ALU operand and select registers, held stable through EXEC and WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a  <= '0;
      r_alu_ry <= '0;
      r_alu_op <= ALU_PASS_A;
    end else if (w_load_ops) begin
      r_alu_a  <= w_opnd_a;
      r_alu_ry <= w_opnd_b;
      r_alu_op <= w_next_alu_op;
    end
  end

  // Output port data and the one-cycle out_valid / illegal pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      if (w_cap_out) r_out_data <= alu_result;
      r_out_valid <= w_cap_out;
      r_illegal   <= w_flag_ill;
    end
  end

  assign instr_ready = (r_state == S_IDLE);
  assign busy_rep    = (r_state == S_REP_EXEC) || (r_state == S_REP_WB);
  assign alu_a       = r_alu_a;
  assign alu_ry      = r_alu_ry;
  assign alu_op      = r_alu_op;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign illegal     = r_illegal;

endmodule
